// File: rtl/readline_arbiter_pkg.sv
// Shared widths and state encoding for the readline arbiter.
package readline_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

endpackage

// File: rtl/readline_arbiter.sv
// Two-port readline arbiter: one grant at a time, held until the line returns.
module readline_arbiter
  import readline_arbiter_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned MAX_WAIT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_readline_do,
  input  logic [ADDR_W-1:0] req0_readline_address,
  output logic              req0_readline_done,
  output logic [LINE_W-1:0] req0_readline_line,

  input  logic              req1_readline_do,
  input  logic [ADDR_W-1:0] req1_readline_address,
  output logic              req1_readline_done,
  output logic [LINE_W-1:0] req1_readline_line,

  output logic              resp_readline_do,
  output logic [ADDR_W-1:0] resp_readline_address,
  input  logic              resp_readline_done,
  input  logic [LINE_W-1:0] resp_readline_line
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                do_q, do_d;
  logic                grant0, grant1;

  // State, latched address, fairness history and memory request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 1'b1;
      wait_q  <= '0;
      do_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      do_q    <= do_d;
    end
  end

  // Grant decision in IDLE and completion tracking while busy.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    wait_d  = wait_q;
    do_d    = do_q;
    grant0  = 1'b0;
    grant1  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_readline_do && req1_readline_do) begin
          if (ROUND_ROBIN) begin
            // last_q == 1 means port 1 went last, so port 0 is next
            if (last_q) grant0 = 1'b1;
            else        grant1 = 1'b1;
          end else begin
            if (wait_q == MAX_WAIT_W) grant1 = 1'b1;
            else                      grant0 = 1'b1;
          end
        end else if (req0_readline_do) begin
          grant0 = 1'b1;
        end else if (req1_readline_do) begin
          grant1 = 1'b1;
        end

        if (grant0) begin
          state_d = BUSY0;
          addr_d  = req0_readline_address;
          last_d  = 1'b0;
          do_d    = 1'b1;
          if (req1_readline_do && (wait_q != MAX_WAIT_W))
            wait_d = wait_q + WAIT_W'(1);
        end
        if (grant1) begin
          state_d = BUSY1;
          addr_d  = req1_readline_address;
          last_d  = 1'b1;
          do_d    = 1'b1;
          wait_d  = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (resp_readline_done) begin
          state_d = IDLE;
          do_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        do_d    = 1'b0;
      end
    endcase
  end

  // Request side is driven from registers; done is forwarded with zero latency.
  assign resp_readline_do      = do_q;
  assign resp_readline_address = addr_q;
  assign req0_readline_done    = (state_q == BUSY0) && resp_readline_done;
  assign req1_readline_done    = (state_q == BUSY1) && resp_readline_done;
  assign req0_readline_line    = resp_readline_line;
  assign req1_readline_line    = resp_readline_line;

endmodule

// File: tb/tb_readline_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b).
module tb_readline_arbiter;
  import readline_arbiter_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              req0_do, req1_do;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              resp_done_a, resp_done_b;
  logic [LINE_W-1:0] resp_line;

  logic              a_done0, a_done1, a_resp_do;
  logic [LINE_W-1:0] a_line0, a_line1;
  logic [ADDR_W-1:0] a_resp_addr;
  logic              b_done0, b_done1, b_resp_do;
  logic [LINE_W-1:0] b_line0, b_line1;
  logic [ADDR_W-1:0] b_resp_addr;

  logic              use_b;
  logic              m_resp_do, m_done0, m_done1;
  logic [ADDR_W-1:0] m_resp_addr;

  int checks;
  int errors;

  assign m_resp_do   = use_b ? b_resp_do   : a_resp_do;
  assign m_resp_addr = use_b ? b_resp_addr : a_resp_addr;
  assign m_done0     = use_b ? b_done0     : a_done0;
  assign m_done1     = use_b ? b_done1     : a_done1;

  readline_arbiter #(.ROUND_ROBIN(1'b1), .MAX_WAIT(3)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_readline_do(req0_do), .req0_readline_address(req0_addr),
    .req0_readline_done(a_done0), .req0_readline_line(a_line0),
    .req1_readline_do(req1_do), .req1_readline_address(req1_addr),
    .req1_readline_done(a_done1), .req1_readline_line(a_line1),
    .resp_readline_do(a_resp_do), .resp_readline_address(a_resp_addr),
    .resp_readline_done(resp_done_a), .resp_readline_line(resp_line)
  );

  readline_arbiter #(.ROUND_ROBIN(1'b0), .MAX_WAIT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_readline_do(req0_do), .req0_readline_address(req0_addr),
    .req0_readline_done(b_done0), .req0_readline_line(b_line0),
    .req1_readline_do(req1_do), .req1_readline_address(req1_addr),
    .req1_readline_done(b_done1), .req1_readline_line(b_line1),
    .resp_readline_do(b_resp_do), .resp_readline_address(b_resp_addr),
    .resp_readline_done(resp_done_b), .resp_readline_line(resp_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    req0_do     = 1'b0;
    req1_do     = 1'b0;
    req0_addr   = '0;
    req1_addr   = '0;
    resp_done_a = 1'b0;
    resp_done_b = 1'b0;
    resp_line   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req0_do     = 1'b0;
    req1_do     = 1'b0;
    req0_addr   = '0;
    req1_addr   = '0;
    resp_done_a = 1'b0;
    resp_done_b = 1'b0;
    resp_line   = '0;
    #3;
    checks++;
    if ({a_resp_do, a_done0, a_done1, b_resp_do, b_done0, b_done1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {a_resp_do, a_done0, a_done1, b_resp_do, b_done0, b_done1});
    end
    checks++;
    if ((a_resp_addr !== '0) || (b_resp_addr !== '0)) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h want 0", a_resp_addr, b_resp_addr);
    end
    checks++;
    if ((a_line0 !== '0) || (a_line1 !== '0) || (b_line0 !== '0) || (b_line1 !== '0)) begin
      errors++;
      $display("FAIL reset_line: got nonzero line outputs");
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [LINE_W-1:0] line;
    line = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    use_b = 1'b0;
    apply_reset();
    req0_addr = 32'h0000_1230;
    req0_do   = 1'b1;
    #1;
    checks++;
    if (a_resp_do !== 1'b0) begin
      errors++;
      $display("FAIL single_no_comb_path: resp_do got %b want 0", a_resp_do);
    end
    step();
    checks++;
    if ((a_resp_do !== 1'b1) || (a_resp_addr !== 32'h0000_1230)) begin
      errors++;
      $display("FAIL single_grant: do=%b addr=%h want 1/00001230", a_resp_do, a_resp_addr);
    end
    resp_line   = line;
    resp_done_a = 1'b1;
    #1;
    checks++;
    if ((a_done0 !== 1'b1) || (a_done1 !== 1'b0) || (a_line0 !== line)) begin
      errors++;
      $display("FAIL single_done: done0=%b done1=%b line=%h want 1/0/%h",
               a_done0, a_done1, a_line0, line);
    end
    step();
    resp_done_a = 1'b0;
    req0_do     = 1'b0;
    #1;
    checks++;
    if ((a_resp_do !== 1'b0) || (a_done0 !== 1'b0)) begin
      errors++;
      $display("FAIL single_release: do=%b done0=%b want 0/0", a_resp_do, a_done0);
    end
  endtask

  // Both ports request continuously; each transfer is 3 busy cycles.
  task automatic test_contention(input bit sel, input int n, input logic [7:0] order);
    logic [ADDR_W-1:0] exp_addr;
    int                waited;
    use_b = sel;
    apply_reset();
    req0_addr = 32'h0000_0100;
    req1_addr = 32'h0000_0200;
    req0_do   = 1'b1;
    req1_do   = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!m_resp_do && waited < 5) begin
        step();
        waited++;
      end
      exp_addr = order[i] ? 32'h0000_0200 : 32'h0000_0100;
      checks++;
      if ((m_resp_do !== 1'b1) || (waited != 0) || (m_resp_addr !== exp_addr)) begin
        errors++;
        $display("FAIL contention%0d_grant%0d: do=%b wait=%0d addr=%h want 1/0/%h",
                 sel, i, m_resp_do, waited, m_resp_addr, exp_addr);
      end
      step();
      step();
      checks++;
      if ((m_resp_do !== 1'b1) || (m_resp_addr !== exp_addr)) begin
        errors++;
        $display("FAIL contention%0d_hold%0d: do=%b addr=%h want 1/%h",
                 sel, i, m_resp_do, m_resp_addr, exp_addr);
      end
      if (sel) resp_done_b = 1'b1;
      else     resp_done_a = 1'b1;
      #1;
      checks++;
      if ({m_done1, m_done0} !== (order[i] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention%0d_done%0d: got %b want %b",
                 sel, i, {m_done1, m_done0}, (order[i] ? 2'b10 : 2'b01));
      end
      step();
      resp_done_a = 1'b0;
      resp_done_b = 1'b0;
      if (i == n - 1) begin
        req0_do = 1'b0;
        req1_do = 1'b0;
      end
      #1;
      checks++;
      if (m_resp_do !== 1'b0) begin
        errors++;
        $display("FAIL contention%0d_gap%0d: do=%b want 0", sel, i, m_resp_do);
      end
      step();
    end
  endtask

  task automatic test_dropout();
    use_b = 1'b0;
    apply_reset();
    req1_addr = 32'h0000_FF00;
    req1_do   = 1'b1;
    step();
    checks++;
    if ((a_resp_do !== 1'b1) || (a_resp_addr !== 32'h0000_FF00)) begin
      errors++;
      $display("FAIL dropout_grant: do=%b addr=%h want 1/0000ff00", a_resp_do, a_resp_addr);
    end
    req1_do   = 1'b0;
    req1_addr = 32'h1111_1111;
    step();
    checks++;
    if ((a_resp_do !== 1'b1) || (a_resp_addr !== 32'h0000_FF00)) begin
      errors++;
      $display("FAIL dropout_hold: do=%b addr=%h want 1/0000ff00", a_resp_do, a_resp_addr);
    end
    resp_done_a = 1'b1;
    #1;
    checks++;
    if ({a_done1, a_done0} !== 2'b10) begin
      errors++;
      $display("FAIL dropout_done: got %b want 10", {a_done1, a_done0});
    end
    step();
    resp_done_a = 1'b0;
    #1;
    checks++;
    if (a_resp_do !== 1'b0) begin
      errors++;
      $display("FAIL dropout_idle: do=%b want 0", a_resp_do);
    end
  endtask

  task automatic test_spurious();
    use_b = 1'b0;
    apply_reset();
    resp_done_a = 1'b1;
    #1;
    checks++;
    if ({a_done1, a_done0} !== 2'b00) begin
      errors++;
      $display("FAIL spurious_done: got %b want 00", {a_done1, a_done0});
    end
    step();
    checks++;
    if (a_resp_do !== 1'b0) begin
      errors++;
      $display("FAIL spurious_state: do=%b want 0", a_resp_do);
    end
    resp_done_a = 1'b0;
    req0_addr   = 32'h0000_0040;
    req0_do     = 1'b1;
    step();
    req0_do = 1'b0;
    checks++;
    if ((a_resp_do !== 1'b1) || (a_resp_addr !== 32'h0000_0040)) begin
      errors++;
      $display("FAIL spurious_after: do=%b addr=%h want 1/00000040", a_resp_do, a_resp_addr);
    end
    resp_done_a = 1'b1;
    step();
    resp_done_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    use_b = 1'b0;
    apply_reset();
    req0_addr = 32'h0000_00A0;
    req0_do   = 1'b1;
    step();
    checks++;
    if (a_resp_do !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_busy: do=%b want 1", a_resp_do);
    end
    rst_n       = 1'b0;
    req0_do     = 1'b0;
    resp_done_a = 1'b1;
    #1;
    checks++;
    if ((a_resp_do !== 1'b0) || (a_resp_addr !== '0) || ({a_done1, a_done0} !== 2'b00)) begin
      errors++;
      $display("FAIL resetmid_async: do=%b addr=%h done=%b want 0/0/00",
               a_resp_do, a_resp_addr, {a_done1, a_done0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ((a_resp_do !== 1'b0) || ({a_done1, a_done0} !== 2'b00)) begin
      errors++;
      $display("FAIL resetmid_late_done: do=%b done=%b want 0/00", a_resp_do, {a_done1, a_done0});
    end
    resp_done_a = 1'b0;
    req1_addr   = 32'h0000_0020;
    req1_do     = 1'b1;
    step();
    req1_do = 1'b0;
    checks++;
    if ((a_resp_do !== 1'b1) || (a_resp_addr !== 32'h0000_0020)) begin
      errors++;
      $display("FAIL resetmid_regrant: do=%b addr=%h want 1/00000020", a_resp_do, a_resp_addr);
    end
    resp_done_a = 1'b1;
    #1;
    checks++;
    if ({a_done1, a_done0} !== 2'b10) begin
      errors++;
      $display("FAIL resetmid_done: got %b want 10", {a_done1, a_done0});
    end
    step();
    resp_done_a = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    use_b  = 1'b0;
    test_reset();
    test_single();
    test_contention(1'b0, 4, 8'b0000_1010);
    test_contention(1'b1, 8, 8'b1000_1000);
    test_dropout();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
